// File: rtl/onehot_decoder_seq_pkg.sv
// decoder_pkg: shared mode/direction encodings and the one-hot encode helper
package decoder_pkg;
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;
    localparam logic DIR_UP      = 1'b0;
    localparam logic DIR_DOWN    = 1'b1;
    localparam int   MAX_OUT_W   = 256;
    function automatic logic [MAX_OUT_W-1:0] onehot(input int unsigned idx, input logic act_low);
        logic [MAX_OUT_W-1:0] r;
        r = MAX_OUT_W'(1) << idx;
        return act_low ? ~r : r;
    endfunction
endpackage

// File: rtl/onehot_decoder_seq_if.sv
// onehot_decoder_seq_if: control inputs (en/mode/dir/sel_in/sel_valid) and decoded outputs (out/idx/wrap)
interface onehot_decoder_seq_if #(parameter int SEL_W = 3);
    localparam int OUT_W = 2**SEL_W;
    logic             en;
    logic             mode;
    logic             dir;
    logic [SEL_W-1:0] sel_in;
    logic             sel_valid;
    logic [OUT_W-1:0] out;
    logic [SEL_W-1:0] idx;
    logic             wrap;
    modport master (output en, mode, dir, sel_in, sel_valid, input out, idx, wrap);
    modport slave  (input en, mode, dir, sel_in, sel_valid, output out, idx, wrap);
endinterface

// File: rtl/onehot_decoder_seq_dwell_tick.sv
// dwell_tick: dwell counter 0..DWELL-1 (ports sys_clk, sys_rst, run, clr -> tick on last count while run)
module dwell_tick #(
    parameter longint unsigned DWELL = 50_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic run,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(DWELL + 1);
    logic [CW-1:0] cnt;
    assign tick = run && cnt == CW'(DWELL - 1);
    always_ff @(posedge sys_clk) begin
        if (sys_rst || clr) cnt <= '0;
        else if (run)       cnt <= tick ? '0 : cnt + CW'(1);
    end
endmodule

// File: rtl/onehot_decoder_seq.sv
// onehot_decoder_seq: registered one-hot decoder with load strobe and dwell-timed auto-scan (sys_clk, sys_rst, bus slave)
module onehot_decoder_seq
    import decoder_pkg::*;
#(
    parameter int              SEL_W       = 3,
    parameter longint unsigned DWELL       = 50_000_000,
    parameter bit              OUT_ACT_LOW = 1'b0
) (
    input logic                 sys_clk,
    input logic                 sys_rst,
    onehot_decoder_seq_if.slave bus
);
    localparam int OUT_W = 2**SEL_W;
    logic             tick;
    logic [SEL_W-1:0] idx, step_idx, idx_next;
    logic [OUT_W-1:0] out;
    logic             wrap, wrap_next;
    // Counter is cleared whenever a load happens or DIRECT mode is active, so a
    // fresh SCAN position (loaded or mode-entered) always gets a full dwell.
    dwell_tick #(.DWELL(DWELL)) u_tick (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .run     (bus.en && bus.mode == MODE_SCAN),
        .clr     (bus.en && (bus.mode == MODE_DIRECT || bus.sel_valid)),
        .tick    (tick)
    );
    always_comb begin
        step_idx  = bus.dir == DIR_DOWN ? idx - SEL_W'(1) : idx + SEL_W'(1);
        idx_next  = !bus.en ? idx : bus.sel_valid ? bus.sel_in : tick ? step_idx : idx;
        wrap_next = bus.en && tick && !bus.sel_valid && (bus.dir == DIR_DOWN ? idx == '0 : idx == '1);
    end
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            idx  <= '0;
            out  <= OUT_W'(onehot(0, OUT_ACT_LOW));
            wrap <= 1'b0;
        end else begin
            idx  <= idx_next;
            out  <= OUT_W'(onehot(int'(idx_next), OUT_ACT_LOW));
            wrap <= wrap_next;
        end
    end
    assign bus.idx  = idx;
    assign bus.out  = out;
    assign bus.wrap = wrap;
endmodule
